// File: rtl/runner_pkg.sv
// Shared definitions for the runner game: FSM state type, default rate/level
// constants, and the helpers that map score to level and level to tick period.
package runner_pkg;

    typedef enum logic [2:0] {
        ST_READY,
        ST_ARM,
        ST_RUN,
        ST_PAUSE,
        ST_OVER
    } run_state_t;

    localparam logic [27:0] DEF_BASE_RATE = 28'd3000000;
    localparam logic [27:0] DEF_RATE_STEP = 28'd250000;
    localparam logic [27:0] DEF_MIN_RATE  = 28'd500000;
    localparam int unsigned DEF_LEVEL_PTS = 16;

    // min(score / pts, cap); a cap of 0 pins the game at level 0.
    function automatic logic [2:0] level_for_score(input logic [15:0] score,
                                                   input int unsigned pts,
                                                   input int unsigned cap);
        int unsigned lvl;
        lvl = 32'(score) / pts;
        if (lvl > cap) lvl = cap;
        return lvl[2:0];
    endfunction

    // max(base - lvl*step, floor_rate), evaluated wide enough that it never wraps.
    function automatic logic [27:0] rate_for_level(input logic [2:0]  lvl,
                                                   input logic [27:0] base,
                                                   input logic [27:0] step,
                                                   input logic [27:0] floor_rate);
        logic [30:0] dec;
        logic [27:0] rate;
        dec  = 31'(lvl) * 31'(step);
        rate = (dec >= 31'(base)) ? '0 : base - dec[27:0];
        return (rate < floor_rate) ? floor_rate : rate;
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Scroll tick down-counter: one registered tick every period+1 enabled cycles,
// with the counter reloaded from period on load or when it expires.
module rate_tick_gen
    import runner_pkg::*;
#(
    parameter logic [27:0] RESET_PERIOD = DEF_BASE_RATE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [27:0] period,
    output logic        tick
);

    logic [27:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_PERIOD;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                count <= period;
            end else if (en) begin
                if (count == '0) begin
                    count <= period;
                    tick  <= 1'b1;
                end else begin
                    count <= count - 28'd1;
                end
            end
        end
    end

endmodule

// File: rtl/runner_sequencer.sv
// Runner game sequencer: game FSM, scroll tick pacing, jump latch, score and level.
// Define RUNNER_SPEEDUP_EN to let the tick period shrink as the level rises.
module runner_sequencer
    import runner_pkg::*;
#(
    parameter logic [27:0] BASE_RATE = DEF_BASE_RATE,
    parameter logic [27:0] RATE_STEP = DEF_RATE_STEP,
    parameter logic [27:0] MIN_RATE  = DEF_MIN_RATE,
    parameter int unsigned LEVEL_PTS = DEF_LEVEL_PTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        stop,
    input  logic        jump,
    input  logic [1:0]  obst_h,
    input  logic [1:0]  runner_h,
    output logic        start,
    output logic        move,
    output logic        tick,
    output logic        jump_go,
    output logic [15:0] score,
    output logic [2:0]  level,
    output logic        game_over
);

`ifdef RUNNER_SPEEDUP_EN
    localparam int unsigned LEVEL_CAP = 7;
`else
    localparam int unsigned LEVEL_CAP = 0;
`endif

    run_state_t  state, state_nx;
    logic [27:0] cur_rate;
    logic        tick_i;
    logic        chk;
    logic        collide;
    logic        jump_q;
    logic        jump_edge;
    logic        jump_lat;

    assign level     = level_for_score(score, LEVEL_PTS, LEVEL_CAP);
    assign cur_rate  = rate_for_level(level, BASE_RATE, RATE_STEP, MIN_RATE);
    assign jump_edge = jump & ~jump_q;
    // chk marks the cycle after a tick, when the datapath has already scrolled.
    assign collide   = chk && (obst_h > runner_h);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_READY;
        else       state <= state_nx;
    end

    // NOTE: state_nx gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_READY: if (go) state_nx = ST_ARM;
            ST_ARM:   state_nx = ST_RUN;
            ST_RUN: begin
                if (collide)   state_nx = ST_OVER;
                else if (stop) state_nx = ST_PAUSE;
            end
            ST_PAUSE: begin
                // A stop in a tick cycle still owes the post-tick collision check.
                if (collide)           state_nx = ST_OVER;
                else if (go && !stop)  state_nx = ST_RUN;
            end
            ST_OVER:  if (go) state_nx = ST_READY;
            default:  state_nx = ST_READY;
        endcase
    end

    // Counting only while RUN persists keeps a tick from landing outside RUN.
    rate_tick_gen #(.RESET_PERIOD(BASE_RATE)) u_rate_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (state inside {ST_READY, ST_ARM, ST_OVER}),
        .en     ((state == ST_RUN) && (state_nx == ST_RUN)),
        .period (cur_rate),
        .tick   (tick_i)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            jump_q   <= 1'b0;
            jump_lat <= 1'b0;
            chk      <= 1'b0;
            score    <= '0;
        end else begin
            jump_q <= jump;
            chk    <= tick_i;
            if (state_nx == ST_READY) begin
                score    <= '0;
                jump_lat <= 1'b0;
            end else begin
                if (chk && !collide && score != 16'hFFFF) score <= score + 16'd1;
                if (tick_i)
                    jump_lat <= jump_edge && (state == ST_RUN);
                else if (jump_edge && state == ST_RUN)
                    jump_lat <= 1'b1;
            end
        end
    end

    assign start     = (state == ST_READY);
    assign move      = (state == ST_RUN);
    assign game_over = (state == ST_OVER);
    assign tick      = tick_i;
    assign jump_go   = tick_i & jump_lat;

endmodule
